uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Buffered UART transmitter inside the SOC; drives the top-level TXD pin.
- Accepts bytes from the CPU memory-mapped IO write path through a small FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed baud rate.
- Exposes FIFO and busy status so firmware can poll before writing.

Parameters:
- CLK_FREQ_HZ, 12000000, system clock frequency.
- BAUD_RATE, 115200, line rate.
- FIFO_DEPTH, 4, byte slots; power of two, at least 2.
- Derived localparam CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, integer division; elaboration error if below 2.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- WR_EN  in  1  one-cycle write strobe from the IO decoder.
- WR_DATA  in  8  byte to transmit.
- FULL  out  1  FIFO holds FIFO_DEPTH bytes.
- EMPTY  out  1  FIFO holds 0 bytes.
- BUSY  out  1  frame in progress, or FIFO not empty.
- OVF  out  1  sticky: a write was dropped because the FIFO was full.
- TXD  out  1  serial line, idle high.

Behaviour:
- Reset state: TXD=1, FIFO count=0, EMPTY=1, FULL=0, BUSY=0, OVF=0, FSM=IDLE, baud counter=0.
- Reset asserted mid-frame: at the next edge TXD=1, the FIFO is flushed, and the partial frame is abandoned.
- FIFO:
  - Circular buffer; read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
- Write rules:
  - WR_EN with FULL=0 stores WR_DATA at the write pointer.
  - WR_EN with FULL=1 drops the byte and sets OVF.
  - FULL is evaluated from the pre-edge count. A write that coincides with a pop while full is still dropped.
- Pop: only in IDLE with EMPTY=0. A simultaneous write and pop leaves count unchanged.
- EMPTY/FULL: registered-count decodes; they update the cycle after the write or pop edge.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: TXD=1. If the FIFO is non-empty: pop the head into shift register sh[7:0], TXD<=0, baud counter<=0, bit index<=0, go to START.
  - START: hold for CLKS_PER_BIT cycles. At counter==CLKS_PER_BIT-1: TXD<=sh[0], counter<=0, go to DATA.
  - DATA: each bit lasts CLKS_PER_BIT cycles. At the end of a bit: shift sh right, increment bit index.
    - After bit 7: TXD<=1, go to STOP.
    - Otherwise: TXD<=next sh[0].
  - STOP: hold TXD=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Back-to-back frames: when STOP ends with the FIFO non-empty, the next frame may start one cycle later. That is one extra idle-high cycle; it is permitted.
- Latency: a write at edge k into an empty FIFO while IDLE makes EMPTY=0 after k. The pop at edge k+1 drives TXD low after k+1.
- Frame length: 10*CLKS_PER_BIT cycles, plus 1 IDLE cycle.
- BUSY = (state != IDLE) | ~EMPTY, combinational from registers.
- TXD comes straight from a flop; no combinational path to the pin.
- OVF clears only on RESET.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame becomes 11 bit-times (8E1).
- Undefined: no PARITY state, no parity logic; 8N1 exactly as above.

Decomposition:
- Package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - Constants: DATA_BITS=8, line idle level=1, start level=0, stop level=1.
  - Function clog2 for pointer widths.
- Sub-module sync_fifo:
  - Parameterised width and depth.
  - Ports: CLK, RESET, wr_en, wr_data, rd_en, rd_data, full, empty.
  - uart_tx_fifo owns the FSM, baud counter, shift register and OVF.

Test Plan:
- Common setup: CLK_FREQ_HZ=400, BAUD_RATE=100, so CLKS_PER_BIT=4.
- Single byte: write 0x55 in IDLE. TXD low from edge k+1 for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. BUSY drops after STOP.
- Back-to-back: write 0xA5,0x0F,0xFF,0x00 on consecutive cycles. Four frames decode correctly in order, EMPTY=1 at the end, OVF=0.
- Overflow: with FIFO_DEPTH=4 and a frame in progress, write 5 more bytes (bytes 1-4 fill the FIFO, the 5th is dropped) → FULL=1, OVF=1 sticky. Only the 4 queued bytes follow the current frame.
- Simultaneous write and pop:
  - FIFO full at a pop edge, WR_EN same cycle → byte dropped, OVF=1, count=3.
  - Count=2 with write and pop together → count stays 2.
- Reset mid-frame: assert RESET during DATA bit 3 → next edge TXD=1, EMPTY=1, BUSY=0, OVF=0. No further low level on TXD until a new write.
- Parity (UART_TX_PARITY_EN defined): send 0x07 → parity bit 1; send 0x03 → parity bit 0. Frame is 44 cycles plus the IDLE cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: transmitter FSM encoding, line levels and a width helper
// shared by the UART transmitter and its FIFO.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam int unsigned DATA_BITS   = 8;
   localparam logic        LINE_IDLE   = 1'b1;
   localparam logic        START_LEVEL = 1'b0;
   localparam logic        STOP_LEVEL  = 1'b1;

   // Bits needed to hold values 0..value-1; never less than one bit.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(value)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock circular buffer with show-ahead read data.
// full/empty decode the registered occupancy count.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   // A write while full is dropped even if a pop happens on the same edge.
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   // Storage array; only occupied slots are ever read, so no reset.
   always_ff @(posedge CLK) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally; count tracks occupancy.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8N1, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 12000000,
   parameter int unsigned BAUD_RATE   = 115200,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       WR_EN,
   input  logic [7:0] WR_DATA,
   output logic       FULL,
   output logic       EMPTY,
   output logic       BUSY,
   output logic       OVF,
   output logic       TXD
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int unsigned CW           = clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    IDX_LAST   = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_tx_fifo: CLKS_PER_BIT must be at least 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
   end

   tx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    sh;
   logic [7:0]    head;
   logic          pop;
`ifdef UART_TX_PARITY_EN
   logic          parity;
`endif

   assign pop  = (state == ST_IDLE) & ~EMPTY;
   assign BUSY = (state != ST_IDLE) | ~EMPTY;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RESET   (RESET),
      .wr_en   (WR_EN),
      .wr_data (WR_DATA),
      .rd_en   (pop),
      .rd_data (head),
      .full    (FULL),
      .empty   (EMPTY)
   );

   // Frame sequencer: TXD is registered here and nowhere else.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         TXD     <= LINE_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
         OVF     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else begin
         if (WR_EN && FULL) OVF <= 1'b1;
         case (state)
            ST_IDLE: begin
               TXD <= LINE_IDLE;
               if (!EMPTY) begin
                  sh      <= head;
                  TXD     <= START_LEVEL;
                  cnt     <= '0;
                  bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                  parity  <= ^head;
`endif
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  TXD   <= sh[0];
                  state <= ST_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt     <= '0;
                  sh      <= {1'b0, sh[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                     TXD   <= parity;
                     state <= ST_PARITY;
`else
                     TXD   <= STOP_LEVEL;
                     state <= ST_STOP;
`endif
                  end else begin
                     TXD <= sh[1];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  TXD   <= STOP_LEVEL;
                  state <= ST_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               TXD   <= LINE_IDLE;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random stimulus against a queue/frame-position
// model of the transmitter; outputs are compared on every falling edge.
module tb_uart_tx_fifo;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       full, empty, busy, ovf, txd;

   uart_tx_fifo #(
      .CLK_FREQ_HZ (400),
      .BAUD_RATE   (100),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .CLK     (clk),
      .RESET   (rst),
      .WR_EN   (wr_en),
      .WR_DATA (wr_data),
      .FULL    (full),
      .EMPTY   (empty),
      .BUSY    (busy),
      .OVF     (ovf),
      .TXD     (txd)
   );

   always #5 clk = ~clk;

   // Reference model: byte queue plus position within the frame on the line.
   logic [7:0] mq[$];
   bit         m_active = 0;
   int         m_pos = 0;
   logic [7:0] m_cur = 8'h00;
   bit         m_ovf = 0;
   bit         m_was_full;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic note_timeout(input string what);
      n_checks++;
      $display("FAIL timeout %s: event not seen within budget at %0t", what, $time);
   endtask

   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (NBITS == 11 && idx == 9) return ^d;
      return 1'b1;
   endfunction

   function automatic logic exp_txd();
      return m_active ? frame_bit(m_cur, m_pos / CPB) : 1'b1;
   endfunction

   // Model step on each rising edge, using the pre-edge queue for pop and full.
   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         m_active = 0;
         m_pos    = 0;
         m_ovf    = 0;
      end else begin
         m_was_full = (mq.size() == DEPTH);
         if (m_active) begin
            m_pos++;
            if (m_pos == FRAME_CYC) m_active = 0;
         end else if (mq.size() > 0) begin
            m_cur    = mq.pop_front();
            m_active = 1;
            m_pos    = 0;
         end
         if (wr_en) begin
            if (m_was_full) m_ovf = 1;
            else mq.push_back(wr_data);
         end
      end
   end

   // Continuous comparison against the model.
   always @(negedge clk) begin
      check("txd",   txd,   exp_txd());
      check("empty", empty, mq.size() == 0);
      check("full",  full,  mq.size() == DEPTH);
      check("busy",  busy,  m_active || mq.size() > 0);
      check("ovf",   ovf,   m_ovf);
   end

   // Called at a falling edge; strobes one byte across the next rising edge.
   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_queue_idle(input int n, input string what);
      for (int i = 0; i < 2000; i++) begin
         if (!m_active && mq.size() == n) return;
         @(negedge clk);
      end
      note_timeout(what);
   endtask

   task automatic wait_pos(input int target, input string what);
      for (int i = 0; i < 2000; i++) begin
         if (m_active && m_pos == target) return;
         @(negedge clk);
      end
      note_timeout(what);
   endtask

   // Sends one byte from idle and samples TXD once per bit-time.
   task automatic send_capture(input logic [7:0] d, output logic [10:0] got);
      got = '0;
      write_byte(d);
      check("lat_empty", empty, 1'b0);
      check("lat_txd_idle", txd, 1'b1);
      @(negedge clk);
      check("lat_txd_start", txd, 1'b0);
      for (int b = 0; b < NBITS; b++) begin
         @(negedge clk);
         got[b] = txd;
         repeat (CPB - 1) @(negedge clk);
      end
   endtask

   logic [10:0] got;
   logic [10:0] exp55;
   int          lows;
   int          pct;

   initial begin
      repeat (3) @(negedge clk);
      check("rst_txd",   txd,   1'b1);
      check("rst_empty", empty, 1'b1);
      check("rst_full",  full,  1'b0);
      check("rst_busy",  busy,  1'b0);
      check("rst_ovf",   ovf,   1'b0);
      rst = 1'b0;
      @(negedge clk);

      // Single byte 0x55
      exp55 = (NBITS == 11) ? 11'h4AA : 11'h2AA;
      send_capture(8'h55, got);
      check("frame_55", got, exp55);
      check("idle_after_frame_busy", busy, 1'b0);
      @(negedge clk);

`ifdef UART_TX_PARITY_EN
      send_capture(8'h07, got);
      check("parity_07", got[9], 1'b1);
      check("stop_07", got[10], 1'b1);
      @(negedge clk);
      send_capture(8'h03, got);
      check("parity_03", got[9], 1'b0);
      @(negedge clk);
`endif

      // Back-to-back writes
      write_byte(8'hA5);
      write_byte(8'h0F);
      write_byte(8'hFF);
      write_byte(8'h00);
      wait_queue_idle(0, "b2b_drain");
      check("b2b_empty", empty, 1'b1);
      check("b2b_ovf",   ovf,   1'b0);

      // Overflow during a frame
      write_byte(8'h11);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 5; i++) write_byte(8'h21 + 8'(i));
      check("ovf_full", full, 1'b1);
      check("ovf_set",  ovf,  1'b1);
      wait_queue_idle(0, "ovf_drain");
      check("ovf_sticky", ovf,   1'b1);
      check("ovf_empty",  empty, 1'b1);

      // Write coinciding with a pop while full
      pulse_reset();
      check("rst2_ovf", ovf, 1'b0);
      write_byte(8'h31);
      @(negedge clk);
      for (int i = 0; i < 4; i++) write_byte(8'h32 + 8'(i));
      wait_queue_idle(4, "full_pop_edge");
      write_byte(8'h36);
      check("fullpop_ovf",  ovf,  1'b1);
      check("fullpop_full", full, 1'b0);
      wait_queue_idle(0, "fullpop_drain");

      // Write coinciding with a pop at count 2
      pulse_reset();
      write_byte(8'h41);
      @(negedge clk);
      write_byte(8'h42);
      write_byte(8'h43);
      wait_queue_idle(2, "cnt2_pop_edge");
      write_byte(8'h44);
      check("cnt2_empty", empty, 1'b0);
      check("cnt2_full",  full,  1'b0);
      write_byte(8'h45);
      write_byte(8'h46);
      check("cnt2_now_full", full, 1'b1);
      check("cnt2_ovf",      ovf,  1'b0);
      wait_queue_idle(0, "cnt2_drain");

      // Reset during data bit 3
      write_byte(8'h5A);
      for (int i = 0; i < 5; i++) write_byte(8'h61 + 8'(i));
      wait_pos(4 * CPB + 1, "data_bit3");
      pulse_reset();
      check("midrst_txd",   txd,   1'b1);
      check("midrst_empty", empty, 1'b1);
      check("midrst_busy",  busy,  1'b0);
      check("midrst_ovf",   ovf,   1'b0);
      lows = 0;
      repeat (3 * FRAME_CYC) begin
         @(negedge clk);
         if (txd !== 1'b1) lows++;
      end
      check("midrst_quiet", lows, 0);

      // Random traffic with varying write density and rare resets
      for (int blk = 0; blk < 8; blk++) begin
         case (blk % 3)
            0:       pct = 2;
            1:       pct = 10;
            default: pct = 40;
         endcase
         repeat (500) begin
            wr_en   = ($urandom_range(0, 99) < pct);
            wr_data = 8'($urandom);
            rst     = ($urandom_range(0, 999) == 0);
            @(negedge clk);
         end
      end
      wr_en = 1'b0;
      rst   = 1'b0;
      wait_queue_idle(0, "final_drain");
      @(negedge clk);
      check("final_empty", empty, 1'b1);
      check("final_busy",  busy,  1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
